// File: rtl/drum_gs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : drum_gs_scheduler
// Purpose  : Arbitrates serial access to the general-storage drum between the
//            CPU (requester 0) and I/O (requester 1). Tracks the drum's angular
//            position from the Z1 bit clock and INDEX, waits for the addressed
//            word to reach the heads, then opens a one-word read/write window.
// Revision : 1.0 - initial release
//
// Ports
//   i_z1              bit clock, all state changes on posedge
//   i_rst             asynchronous reset, active-high
//   i_index           high for one cycle at bit 0 of word 0 (resyncs position)
//   i_req0/i_req1     access request, held high until the matching done pulse
//   i_wr0/i_wr1       1 = write, 0 = read; sampled at grant
//   i_adr0/i_adr1     {track, word}; sampled at grant
//   i_din0/i_din1     serial write data, MSB first, during the window
//   i_rd              serial read data from the drum
//   o_gnt0/o_gnt1     requester owns the drum (grant through done)
//   o_done0/o_done1   one-cycle completion pulse
//   o_track           track select to the drum (0 while idle)
//   o_w1              drum write enable, high only inside a write window
//   o_wdata           serial data to the drum
//   o_rdata           serial read data to the granted requester
//   o_rvalid          o_rdata qualifier
//
// Configuration macro
//   DRUM_SCHED_LOOKAHEAD_EN : when both requesters contend in IDLE, grant the
//                             one whose word arrives soonest; ties fall back to
//                             round-robin. Undefined: pure round-robin.
// ============================================================================
module drum_gs_scheduler #(
  parameter int WORD_BITS = 40,
  parameter int WORDS     = 128,
  parameter int TRACK_W   = 5
) (
  input  logic                                i_z1,
  input  logic                                i_rst,
  input  logic                                i_index,
  input  logic                                i_req0,
  input  logic                                i_req1,
  input  logic                                i_wr0,
  input  logic                                i_wr1,
  input  logic [TRACK_W+$clog2(WORDS)-1:0]    i_adr0,
  input  logic [TRACK_W+$clog2(WORDS)-1:0]    i_adr1,
  input  logic                                i_din0,
  input  logic                                i_din1,
  input  logic                                i_rd,
  output logic                                o_gnt0,
  output logic                                o_gnt1,
  output logic                                o_done0,
  output logic                                o_done1,
  output logic [TRACK_W-1:0]                  o_track,
  output logic                                o_w1,
  output logic                                o_wdata,
  output logic                                o_rdata,
  output logic                                o_rvalid
);

  localparam int c_BIT_W  = $clog2(WORD_BITS);
  localparam int c_WORD_W = $clog2(WORDS);
  localparam int c_ADR_W  = TRACK_W + c_WORD_W;

  localparam logic [c_BIT_W-1:0]  c_LAST_BIT  = c_BIT_W'(WORD_BITS - 1);
  localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Drum angular position
  // --------------------------------------------------------------------------
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [c_WORD_W-1:0] r_word_cnt;
  logic [c_WORD_W-1:0] w_next_word;
  logic                w_last_bit;

  assign w_last_bit  = (r_bit_cnt == c_LAST_BIT);
  assign w_next_word = (r_word_cnt == c_LAST_WORD) ? '0 : r_word_cnt + c_WORD_W'(1);

  always_ff @(posedge i_z1 or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (i_index) begin
      // INDEX realigns the counters regardless of where they think they are.
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (w_last_bit) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= w_next_word;
    end else begin
      r_bit_cnt  <= r_bit_cnt + c_BIT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration (evaluated only while IDLE)
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_last;   // requester granted most recently
  logic                  r_sel;    // requester currently owning the drum
  logic                  r_wr;
  logic [c_WORD_W-1:0]   r_target;
  logic [TRACK_W-1:0]    r_track;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_done0;
  logic                  r_done1;

  logic                  w_pick1;
  logic [c_ADR_W-1:0]    w_adr_pick;
  logic                  w_req_sel;

`ifdef DRUM_SCHED_LOOKAHEAD_EN
  // Words until the target arrives at the heads; wraps naturally because the
  // word counter spans the whole track (WORDS is a power of two).
  logic [c_WORD_W-1:0] w_dist0;
  logic [c_WORD_W-1:0] w_dist1;
  assign w_dist0 = i_adr0[c_WORD_W-1:0] - r_word_cnt - c_WORD_W'(1);
  assign w_dist1 = i_adr1[c_WORD_W-1:0] - r_word_cnt - c_WORD_W'(1);
`endif

  always_comb begin
    w_pick1 = i_req1;
    if (i_req0 && i_req1) begin
`ifdef DRUM_SCHED_LOOKAHEAD_EN
      if (w_dist0 < w_dist1) begin
        w_pick1 = 1'b0;
      end else if (w_dist1 < w_dist0) begin
        w_pick1 = 1'b1;
      end else begin
        w_pick1 = ~r_last;
      end
`else
      w_pick1 = ~r_last;
`endif
    end
  end

  assign w_adr_pick = w_pick1 ? i_adr1 : i_adr0;
  assign w_req_sel  = r_sel ? i_req1 : i_req0;

  // --------------------------------------------------------------------------
  // Access sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge i_z1 or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;        // requester 0 wins the first contention
      r_sel    <= 1'b0;
      r_wr     <= 1'b0;
      r_target <= '0;
      r_track  <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req0 || i_req1) begin
            r_sel    <= w_pick1;
            r_last   <= w_pick1;
            r_gnt0   <= ~w_pick1;
            r_gnt1   <= w_pick1;
            r_wr     <= w_pick1 ? i_wr1 : i_wr0;
            r_target <= w_adr_pick[c_WORD_W-1:0];
            r_track  <= w_adr_pick[c_ADR_W-1:c_WORD_W];
            r_state  <= S_SEEK;
          end
        end
        S_SEEK: begin
          if (!w_req_sel) begin
            // Abandoned before the window opened: nothing touched the drum.
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_track <= '0;
            r_state <= S_IDLE;
          end else if (w_last_bit && (w_next_word == r_target)) begin
            // Entering only from the last bit of the preceding word means a
            // target equal to the current word costs a full revolution.
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          // Window always runs to the end of the word, request or not.
          if (w_last_bit) begin
            r_done0 <= ~r_sel;
            r_done1 <= r_sel;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_track <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_track <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Serial datapath (combinational pass-through inside the window)
  // --------------------------------------------------------------------------
  logic w_xfer;
  logic w_din_sel;

  assign w_xfer    = (r_state == S_XFER);
  assign w_din_sel = r_sel ? i_din1 : i_din0;

  assign o_w1     = w_xfer & r_wr;
  assign o_wdata  = w_xfer & r_wr & w_din_sel;
  assign o_rvalid = w_xfer & ~r_wr;
  assign o_rdata  = w_xfer & ~r_wr & i_rd;

  assign o_gnt0   = r_gnt0;
  assign o_gnt1   = r_gnt1;
  assign o_done0  = r_done0;
  assign o_done1  = r_done1;
  assign o_track  = r_track;

endmodule
`default_nettype wire

// File: tb/tb_drum_gs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_drum_gs_scheduler
// Purpose  : Directed self-checking bench for drum_gs_scheduler. A small drum
//            model tracks position independently and stores one written word
//            so it can be played back on the read line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drum_gs_scheduler;

  logic        clk;
  logic        rst;
  logic        index;
  logic        req0, req1, wr0, wr1;
  logic [11:0] adr0, adr1;
  logic        din0, din1, rd;
  logic        gnt0, gnt1, done0, done1;
  logic [4:0]  track;
  logic        w1, wdata, rdata, rvalid;

  int vectors;
  int miscompares;

  drum_gs_scheduler dut (
    .i_z1     (clk),
    .i_rst    (rst),
    .i_index  (index),
    .i_req0   (req0),
    .i_req1   (req1),
    .i_wr0    (wr0),
    .i_wr1    (wr1),
    .i_adr0   (adr0),
    .i_adr1   (adr1),
    .i_din0   (din0),
    .i_din1   (din1),
    .i_rd     (rd),
    .o_gnt0   (gnt0),
    .o_gnt1   (gnt1),
    .o_done0  (done0),
    .o_done1  (done1),
    .o_track  (track),
    .o_w1     (w1),
    .o_wdata  (wdata),
    .o_rdata  (rdata),
    .o_rvalid (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drum model: its own notion of angular position plus one stored word.
  logic [5:0]  tb_bit;
  logic [6:0]  tb_word;
  logic [39:0] store;
  logic [39:0] c_pat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_bit  <= 6'd0;
      tb_word <= 7'd0;
    end else if (index) begin
      tb_bit  <= 6'd0;
      tb_word <= 7'd0;
    end else if (tb_bit == 6'd39) begin
      tb_bit  <= 6'd0;
      tb_word <= tb_word + 7'd1;
    end else begin
      tb_bit  <= tb_bit + 6'd1;
    end
  end

  always @(posedge clk) begin
    if (w1) store[6'd39 - tb_bit] <= wdata;
  end

  assign din0 = c_pat[6'd39 - tb_bit];
  assign din1 = 1'b0;
  assign rd   = store[6'd39 - tb_bit];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          n;
    logic        trk_bad;
    logic        wbad;
    logic [39:0] rcap;
    logic [1:0]  pair_exp1;
    logic [1:0]  pair_exp2;

    vectors     = 0;
    miscompares = 0;
    c_pat       = 40'hA5_0F_F0_12_34;
    store       = 40'd0;
    rst = 1'b1; index = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    adr0 = 12'd0; adr1 = 12'd0;

`ifdef DRUM_SCHED_LOOKAHEAD_EN
    pair_exp1 = 2'b01;
    pair_exp2 = 2'b01;
`else
    pair_exp1 = 2'b10;
    pair_exp2 = 2'b01;
`endif

    // ---- reset values ----
    #12;
    check("reset_outputs", {gnt0, gnt1, done0, done1, track, w1, wdata, rvalid, rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- INDEX resync: DUT must follow the model's realignment ----
    repeat (77) @(negedge clk);
    index = 1'b1;
    @(negedge clk);
    index = 1'b0;

    // ---- write word {3,10} via requester 0 ----
    adr0 = {5'd3, 7'd10}; wr0 = 1'b1; req0 = 1'b1;
    @(negedge clk);
    check("wr_gnt", {gnt0, gnt1}, 64'b10);
    check("wr_track", track, 64'd3);
    n = 0;
    while (!w1 && n < 6000) begin @(negedge clk); n++; end
    check("wr_window_open", w1, 64'd1);
    check("wr_window_pos", {tb_word, tb_bit}, {51'd0, 7'd10, 6'd0});
    n = 0; trk_bad = 1'b0;
    while (w1 && n < 100) begin
      if (track !== 5'd3) trk_bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("wr_window_len", n, 64'd40);
    check("wr_track_hold", trk_bad, 64'd0);
    check("wr_done_pulse", {gnt0, done0, done1}, 64'b110);
    req0 = 1'b0; wr0 = 1'b0;
    @(negedge clk);
    check("wr_release", {gnt0, gnt1, done0, track}, 64'd0);
    check("wr_stored", store, {24'd0, 40'hA5_0F_F0_12_34});

    // ---- read back the same word via requester 1 ----
    adr1 = {5'd3, 7'd10}; wr1 = 1'b0; req1 = 1'b1;
    @(negedge clk);
    check("rd_gnt", {gnt0, gnt1}, 64'b01);
    n = 0;
    while (!rvalid && n < 6000) begin
      if (w1) wbad = 1'b1;
      @(negedge clk); n++;
    end
    check("rd_window_open", rvalid, 64'd1);
    n = 0; wbad = 1'b0; rcap = 40'd0;
    while (rvalid && n < 100) begin
      rcap = {rcap[38:0], rdata};
      if (w1 || wdata) wbad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("rd_window_len", n, 64'd40);
    check("rd_data", rcap, {24'd0, 40'hA5_0F_F0_12_34});
    check("rd_no_write", wbad, 64'd0);
    check("rd_done_pulse", {gnt1, done1, done0}, 64'b110);
    req1 = 1'b0;
    @(negedge clk);

    // ---- simultaneous requests after reset, then drop in SEEK ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    adr0 = {5'd1, 7'd100}; adr1 = {5'd2, 7'd5};
    wr0 = 1'b0; wr1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    check("pair1_gnt", {gnt0, gnt1}, {62'd0, pair_exp1});
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("seek_drop", {gnt0, gnt1, done0, done1, w1, track}, 64'd0);
    @(negedge clk);
    check("seek_drop_idle", {gnt0, gnt1, done0, done1, w1}, 64'd0);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    check("pair2_gnt", {gnt0, gnt1}, {62'd0, pair_exp2});
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("pair2_drop", {gnt0, gnt1, done0, done1, w1}, 64'd0);

    // ---- target equal to current word: full revolution ----
    n = 0;
    while (!(tb_word == 7'd20 && tb_bit == 6'd5) && n < 6000) begin @(negedge clk); n++; end
    adr0 = {5'd7, 7'd20}; wr0 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    check("rev_gnt_track", {gnt0, track}, {58'd0, 1'b1, 5'd7});
    n = 0;
    while (!rvalid && n < 6000) begin @(negedge clk); n++; end
    check("rev_latency_range", (n >= 5080 && n <= 5119), 64'd1);
    check("rev_window_pos", {tb_word, tb_bit}, {51'd0, 7'd20, 6'd0});
    n = 0;
    while (!done0 && n < 60) begin @(negedge clk); n++; end
    check("rev_done", {done0, gnt0, w1}, 64'b110);
    req0 = 1'b0;
    @(negedge clk);

    // ---- asynchronous reset in the middle of a write ----
    adr0 = {5'd4, tb_word + 7'd3}; wr0 = 1'b1; req0 = 1'b1;
    n = 0;
    while (!w1 && n < 6000) begin @(negedge clk); n++; end
    check("rst_write_open", w1, 64'd1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {gnt0, gnt1, done0, done1, track, w1, wdata, rvalid, rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0; wr0 = 1'b0;
    @(negedge clk);
    check("rst_after", {gnt0, gnt1, done0, done1, track, w1, rvalid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
